// File: rtl/regfile_ports.sv
// Parametrised register file with registered reads, write-to-read bypass,
// optional hardwired zero register and a sequential post-reset clear sweep.
module regfile_ports #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic                    busy
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [AW-1:0]     clear_idx;
  logic [AW-1:0]     next_clear_idx;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem [NREGS];
  logic [AW-1:0]     ra [NREAD];
  logic [NREAD*XLEN-1:0] rd_next;

  // State register and clear sweep index
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state     <= next_state;
      clear_idx <= next_clear_idx;
    end
  end

  // Next state, busy and the single memory write port (sweep or host)
  always_comb begin
    next_state     = state;
    next_clear_idx = clear_idx;
    busy           = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_addr;
    mem_wdata      = wr_data;
    case (state)
      CLEAR: begin
        busy           = 1'b1;
        mem_we         = 1'b1;
        mem_waddr      = clear_idx;
        mem_wdata      = '0;
        next_clear_idx = clear_idx + AW'(1);
        if (clear_idx == AW'(NREGS - 1)) next_state = READY;
      end
      READY: begin
        mem_we = wr_en && !(ZERO_REG && (wr_addr == '0));
      end
      default: next_state = CLEAR;
    endcase
  end

  // Storage has no reset so it can map onto block RAM; reset cycle leaves it untouched
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Per-port read value: zero during sweep, zero register, bypass, else memory
  always_comb begin
    rd_next = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      ra[p] = rd_addr[p*AW +: AW];
      if (state == CLEAR) begin
        rd_next[p*XLEN +: XLEN] = '0;
      end else if (ZERO_REG && (ra[p] == '0)) begin
        rd_next[p*XLEN +: XLEN] = '0;
      end else if (BYPASS && mem_we && (mem_waddr == ra[p])) begin
        rd_next[p*XLEN +: XLEN] = wr_data;
      end else begin
        rd_next[p*XLEN +: XLEN] = mem[ra[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: tb/tb_regfile_ports.sv
// Self-checking bench for regfile_ports: four parameterisations driven together
// and compared every cycle against an array-based reference model.
module tb_regfile_ports;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_d, rd_nb, rd_nz;
  logic        busy_d, busy_nb, busy_nz;

  logic         w_wr_en;
  logic [3:0]   w_wr_addr;
  logic [63:0]  w_wr_data;
  logic [11:0]  w_rd_addr;
  logic [191:0] rd_w;
  logic         busy_w;

  always #5 clk = ~clk;

  regfile_ports dut_d (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_d), .busy(busy_d));

  regfile_ports #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_nb), .busy(busy_nb));

  regfile_ports #(.ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_nz), .busy(busy_nz));

  regfile_ports #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_w (
    .clk(clk), .reset(reset), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_addr(w_rd_addr), .rd_data(rd_w), .busy(busy_w));

  // Reference model configuration: default, no-bypass, no-zero-reg, wide
  int nregs [NC] = '{32, 32, 32, 16};
  int nrd   [NC] = '{2, 2, 2, 3};
  bit byp   [NC] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit zr    [NC] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic [63:0] mm    [NC][32];
  logic [63:0] erd   [NC][3];
  int          clr   [NC];
  bit          ebusy [NC];
  bit          valid = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the behavioural model for configuration c
  task automatic model_step(input int c, input bit rst, input bit we, input int wa,
                            input logic [63:0] wd, input int ra0, input int ra1, input int ra2);
    int ra [3];
    bit drop;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    if (rst) begin
      clr[c] = nregs[c];
      for (int p = 0; p < 3; p++) erd[c][p] = '0;
    end else if (clr[c] > 0) begin
      mm[c][nregs[c] - clr[c]] = '0;
      clr[c]--;
      for (int p = 0; p < 3; p++) erd[c][p] = '0;
    end else begin
      drop = zr[c] && (wa == 0);
      for (int p = 0; p < nrd[c]; p++) begin
        if (zr[c] && ra[p] == 0)                     erd[c][p] = '0;
        else if (byp[c] && we && !drop && wa == ra[p]) erd[c][p] = wd;
        else                                           erd[c][p] = mm[c][ra[p]];
      end
      if (we && !drop) mm[c][wa] = wd;
    end
    ebusy[c] = (clr[c] > 0);
  endtask

  task automatic tick();
    for (int c = 0; c < 3; c++)
      model_step(c, reset, wr_en, int'(wr_addr), 64'(wr_data),
                 int'(rd_addr[4:0]), int'(rd_addr[9:5]), 0);
    model_step(3, reset, w_wr_en, int'(w_wr_addr), w_wr_data,
               int'(w_rd_addr[3:0]), int'(w_rd_addr[7:4]), int'(w_rd_addr[11:8]));
    if (reset) valid = 1'b1;
    @(posedge clk);
    #1;
    if (valid) begin
      check("busy_d",  64'(busy_d),  64'(ebusy[0]));
      check("busy_nb", 64'(busy_nb), 64'(ebusy[1]));
      check("busy_nz", 64'(busy_nz), 64'(ebusy[2]));
      check("busy_w",  64'(busy_w),  64'(ebusy[3]));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rd_d p%0d", p),  64'(rd_d[p*32 +: 32]),  erd[0][p]);
        check($sformatf("rd_nb p%0d", p), 64'(rd_nb[p*32 +: 32]), erd[1][p]);
        check($sformatf("rd_nz p%0d", p), 64'(rd_nz[p*32 +: 32]), erd[2][p]);
      end
      for (int p = 0; p < 3; p++)
        check($sformatf("rd_w p%0d", p), rd_w[p*64 +: 64], erd[3][p]);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;

    // Initial reset and sweep
    tick();
    check("reset busy", 64'(busy_d), 64'(1));
    check("reset rd", rd_d, 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 32; i++) tick();

    // Clear sweep after dirtying every register
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hDEADBEEF; tick();
    end
    wr_en = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 15) check("wide busy e15", 64'(busy_w), 64'(1));
      if (i == 16) check("wide busy e16", 64'(busy_w), 64'(0));
      if (i == 31) check("busy e31", 64'(busy_d), 64'(1));
      if (i == 32) check("busy e32", 64'(busy_d), 64'(0));
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)}; tick();
      check("sweep zero", rd_d, 64'(0));
    end

    // Basic write then read
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; tick();
    wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; tick();
    wr_en = 1'b0; rd_addr = {5'd9, 5'd5}; tick();
    check("basic p0", 64'(rd_d[31:0]),  64'(32'h12345678));
    check("basic p1", 64'(rd_d[63:32]), 64'(32'hA5A5A5A5));

    // Bypass versus read-before-write
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111; rd_addr = '0; tick();
    wr_data = 32'h22222222; rd_addr = {5'd0, 5'd7}; tick();
    check("bypass on", 64'(rd_d[31:0]),  64'(32'h22222222));
    check("bypass off", 64'(rd_nb[31:0]), 64'(32'h11111111));
    wr_en = 1'b0; tick();
    check("bypass off later", 64'(rd_nb[31:0]), 64'(32'h22222222));

    // Hardwired zero register
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd3}; tick();
    check("zero same", 64'(rd_d[63:32]), 64'(0));
    check("nozero same", 64'(rd_nz[63:32]), 64'(32'hFFFFFFFF));
    wr_en = 1'b0; tick();
    check("zero later", 64'(rd_d[63:32]), 64'(0));
    check("nozero later", 64'(rd_nz[63:32]), 64'(32'hFFFFFFFF));

    // Wide configuration, all three ports on one register
    w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 64'h0123456789ABCDEF; tick();
    w_wr_en = 1'b0; w_rd_addr = {4'd15, 4'd15, 4'd15}; tick();
    for (int p = 0; p < 3; p++) check("wide r15", rd_w[p*64 +: 64], 64'h0123456789ABCDEF);

    // Reset mid-clear, with host writes ignored while busy
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; tick();
    reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) check("restart busy e31", 64'(busy_d), 64'(1));
      if (i == 32) check("restart busy e32", 64'(busy_d), 64'(0));
    end
    wr_en = 1'b0; rd_addr = {5'd3, 5'd3}; tick();
    check("r3 after clear", rd_d, 64'(0));

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 149) == 0);
      wr_en     = 1'($urandom);
      wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr[4:0] : 5'($urandom);
      wr_data   = $urandom;
      rd_addr   = 10'($urandom);
      w_wr_en   = 1'($urandom);
      w_wr_addr = 4'($urandom);
      w_wr_data = {$urandom, $urandom};
      w_rd_addr = ($urandom_range(0, 3) == 0) ? {3{w_wr_addr}} : 12'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
